// File: rtl/soc_system_cpu_s1_mul_pkg.sv
// rtl/soc_system_cpu_s1_mul_pkg.sv - shared constants, helpers and tag type for the shared multiplier
package soc_system_cpu_s1_mul_pkg;

  localparam int MUL_DATA_W = 32;
  localparam int PERF_CNT_W = 16;
  localparam int MUL_ID_W   = 3;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  typedef struct packed {
    logic                valid;
    logic [MUL_ID_W-1:0] id;
  } mul_tag_t;

endpackage

// File: rtl/soc_system_cpu_s1_rr_arbiter.sv
// rtl/soc_system_cpu_s1_rr_arbiter.sv - combinational round-robin arbiter starting at rr_ptr
module soc_system_cpu_s1_rr_arbiter
  import soc_system_cpu_s1_mul_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  int               sum;
  logic [IDX_W-1:0] idx;
  logic             found;

  // Walk the search order backwards so the first hit in rotation order is written last.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = 0;
    idx       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = int'(rr_ptr) + k;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      idx = IDX_W'(sum);
      if (req[idx]) begin
        found     = 1'b1;
        grant_idx = idx;
      end
    end
    if (found) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/soc_system_cpu_s1_mul_arbiter.sv
// rtl/soc_system_cpu_s1_mul_arbiter.sv - shares one pipelined multiplier cell among NUM_REQ requesters
module soc_system_cpu_s1_mul_arbiter
  import soc_system_cpu_s1_mul_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int MUL_LATENCY = 1,
  parameter int ID_W        = 3
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*MUL_DATA_W-1:0] req_src1,
  input  logic [NUM_REQ*MUL_DATA_W-1:0] req_src2,
  output logic [NUM_REQ-1:0]            grant,
  output logic [MUL_DATA_W-1:0]         mul_src1,
  output logic [MUL_DATA_W-1:0]         mul_src2,
  input  logic [MUL_DATA_W-1:0]         mul_result,
  output logic                          resp_valid,
  output logic [ID_W-1:0]               resp_id,
  output logic [MUL_DATA_W-1:0]         resp_result,
  output logic [PERF_CNT_W-1:0]         perf_issue_cnt
);

  localparam int PTR_W = clog2(NUM_REQ);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] grant_idx;
  logic             issue;
  tag_t             tag_pipe [MUL_LATENCY];

  soc_system_cpu_s1_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (PTR_W)
  ) u_rr_arbiter (
    .req       (req),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign issue = |grant;

  // Only the granted slice is ever selected, so junk on idle requesters stays off the cell inputs.
  always_comb begin
    mul_src1 = '0;
    mul_src2 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        mul_src1 = req_src1[MUL_DATA_W*i +: MUL_DATA_W];
        mul_src2 = req_src2[MUL_DATA_W*i +: MUL_DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (issue) begin
      rr_ptr <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < MUL_LATENCY; s++) tag_pipe[s] <= '0;
    end else begin
      tag_pipe[0] <= tag_t'{valid: issue, id: ID_W'(grant_idx)};
      for (int s = 1; s < MUL_LATENCY; s++) tag_pipe[s] <= tag_pipe[s-1];
    end
  end

  assign resp_valid  = tag_pipe[MUL_LATENCY-1].valid;
  assign resp_id     = tag_pipe[MUL_LATENCY-1].id;
  assign resp_result = mul_result;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_issue_cnt <= '0;
    end else if (issue && (perf_issue_cnt != '1)) begin
      perf_issue_cnt <= perf_issue_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_soc_system_cpu_s1_mul_arbiter.sv
// tb/tb_soc_system_cpu_s1_mul_arbiter.sv - randomized self-checking bench for the shared multiplier arbiter
module tb_soc_system_cpu_s1_mul_arbiter;

  localparam int N   = 3;
  localparam int LAT = 3;
  localparam int IW  = 3;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*32-1:0] req_src1 = '0;
  logic [N*32-1:0] req_src2 = '0;
  logic [N-1:0]    grant;
  logic [31:0]     mul_src1, mul_src2, mul_result;
  logic            resp_valid;
  logic [IW-1:0]   resp_id;
  logic [31:0]     resp_result;
  logic [15:0]     perf_issue_cnt;

  always #5 clk = ~clk;

  soc_system_cpu_s1_mul_arbiter #(
    .NUM_REQ     (N),
    .MUL_LATENCY (LAT),
    .ID_W        (IW)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req            (req),
    .req_src1       (req_src1),
    .req_src2       (req_src2),
    .grant          (grant),
    .mul_src1       (mul_src1),
    .mul_src2       (mul_src2),
    .mul_result     (mul_result),
    .resp_valid     (resp_valid),
    .resp_id        (resp_id),
    .resp_result    (resp_result),
    .perf_issue_cnt (perf_issue_cnt)
  );

  // Multiplier cell stand-in with LAT register stages.
  logic [31:0] cell_pipe [LAT];
  always @(posedge clk) begin
    cell_pipe[0] <= mul_src1 * mul_src2;
    for (int s = 1; s < LAT; s++) cell_pipe[s] <= cell_pipe[s-1];
  end
  assign mul_result = cell_pipe[LAT-1];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model state: pointer, saturating count, responses keyed by cycle slot.
  int          m_ptr = 0;
  int          m_cnt = 0;
  bit          rv   [8];
  int          rid  [8];
  logic [31:0] rres [8];

  typedef struct {
    int          c;
    int          kind;
    logic [31:0] val;
  } pin_t;
  pin_t pins[$];
  pin_t keep[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    int              g;
    logic [N-1:0]    eg, sh;
    logic [N*32-1:0] t1, t2;
    logic [31:0]     ea, eb;
    logic [2:0]      slot, fslot;

    if (!reset_n) begin
      m_ptr = 0;
      m_cnt = 0;
      for (int i = 0; i < 8; i++) rv[i] = 1'b0;
    end

    slot = 3'(cyc);
    chk("resp_valid", resp_valid, 32'(rv[slot]));
    if (rv[slot]) begin
      chk("resp_id", resp_id, rid[slot]);
      chk("resp_result", resp_result, rres[slot]);
    end
    rv[slot] = 1'b0;

    g = -1;
    for (int k = 0; k < N; k++) begin
      sh = req >> ((m_ptr + k) % N);
      if (g < 0 && sh[0]) g = (m_ptr + k) % N;
    end
    eg = '0; ea = '0; eb = '0;
    if (g >= 0) begin
      eg = N'(1) << g;
      t1 = req_src1 >> (32 * g);
      t2 = req_src2 >> (32 * g);
      ea = t1[31:0];
      eb = t2[31:0];
    end
    chk("grant", grant, eg);
    chk("mul_src1", mul_src1, ea);
    chk("mul_src2", mul_src2, eb);
    chk("perf_issue_cnt", perf_issue_cnt, m_cnt);

    if (g >= 0 && reset_n) begin
      m_ptr = (g + 1) % N;
      if (m_cnt < 65535) m_cnt++;
      fslot = 3'(cyc + LAT);
      rv[fslot]   = 1'b1;
      rid[fslot]  = g;
      rres[fslot] = ea * eb;
    end

    keep.delete();
    foreach (pins[i]) begin
      if (pins[i].c == cyc) begin
        case (pins[i].kind)
          0: chk("pin_grant", grant, pins[i].val);
          1: begin
            chk("pin_resp_valid", resp_valid, 1);
            chk("pin_resp_result", resp_result, pins[i].val);
          end
          2: chk("pin_perf", perf_issue_cnt, pins[i].val);
          default: chk("pin_resp_valid_low", resp_valid, pins[i].val);
        endcase
      end else begin
        keep.push_back(pins[i]);
      end
    end
    pins = keep;
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pin(input int c, input int kind, input logic [31:0] v);
    pins.push_back('{c, kind, v});
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_src1[32*i +: 32] = a;
    req_src2[32*i +: 32] = b;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req = '0;
    repeat (2) tick();
    reset_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] gs;

    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    pin(cyc, 0, 0);
    pin(cyc, 2, 0);
    pin(cyc, 3, 0);
    tick();

    // Single op from requester 0.
    set_op(0, 32'h0001_0003, 32'h0000_0005);
    req = 3'b001;
    pin(cyc, 0, 32'b001);
    pin(cyc + LAT, 1, 32'h0005_000F);
    tick();
    req = '0;
    repeat (4) tick();

    // Grant index 1 moves the pointer to 2, then 3'b101 wraps 2 -> 0.
    set_op(1, 32'd3, 32'd4);
    req = 3'b010;
    pin(cyc, 0, 32'b010);
    tick();
    set_op(2, 32'hFFFF_FFFF, 32'd2);
    set_op(0, 32'd7, 32'd9);
    req = 3'b101;
    pin(cyc, 0, 32'b100);
    pin(cyc + LAT, 1, 32'hFFFF_FFFE);
    tick();
    req = 3'b001;
    pin(cyc, 0, 32'b001);
    pin(cyc + LAT, 1, 32'd63);
    tick();
    req = '0;
    repeat (4) tick();

    // Back-to-back single requester.
    do_reset();
    for (int n = 1; n <= 5; n++) begin
      set_op(1, n, n);
      req = 3'b010;
      pin(cyc + LAT, 1, n * n);
      tick();
    end
    req = '0;
    pin(cyc, 2, 5);
    repeat (4) tick();

    // Randomized traffic following the hold-until-granted protocol.
    gs = '0;
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] || gs[i]) begin
          req[i] = ($urandom_range(0, 9) < 6);
          set_op(i, $urandom, ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom);
        end
      end
      #1;
      gs = grant;
      @(posedge clk);
      #1;
    end
    req = '0;
    repeat (4) tick();

    // Reset while an op is in flight.
    set_op(0, 32'd11, 32'd13);
    req = 3'b001;
    pin(cyc + LAT, 3, 0);
    tick();
    reset_n = 1'b0;
    req = '0;
    repeat (3) tick();
    reset_n = 1'b1;
    pin(cyc, 2, 0);
    set_op(1, 32'd5, 32'd6);
    req = 3'b011;
    pin(cyc, 0, 32'b001);
    tick();
    req = '0;
    repeat (4) tick();

    // Saturation of the issue counter.
    do_reset();
    for (int t = 0; t < 65540; t++) begin
      set_op(2, $urandom, $urandom);
      req = 3'b100;
      tick();
    end
    req = '0;
    pin(cyc, 2, 32'h0000_FFFF);
    pin(cyc, 0, 0);
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/soc_system_cpu_s1_mul_arbiter.md
Name: soc_system_cpu_s1_mul_arbiter

Overview:
- Shares one pipelined 32x32->32 multiplier cell (low 32 bits of the product, fixed latency) between NUM_REQ independent requesters.
- Round-robin arbitration issues at most one multiply per cycle.
- Carries a requester-ID tag down a shift pipeline matched to the cell latency, then returns each result to its originator.
- Sits between the CPU/accelerator requesters and the multiplier cell instance in the soc_system CPU subsystem.

Parameters:
- NUM_REQ, 2: number of requesters; legal range 2..8.
- MUL_LATENCY, 1: clock edges from operands presented to the cell until its result output is valid; legal range 1..4.
- ID_W, 3: width of the requester ID; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester request; held high with stable operands until granted.
- req_src1  in  NUM_REQ*32  packed operand A; requester i uses bits [32*i+31:32*i].
- req_src2  in  NUM_REQ*32  packed operand B; same packing as req_src1.
- grant  out  NUM_REQ  one-hot combinational grant, asserted in the issue cycle.
- mul_src1  out  32  operand A to the multiplier cell.
- mul_src2  out  32  operand B to the multiplier cell.
- mul_result  in  32  multiplier cell result (low 32 bits of the product).
- resp_valid  out  1  result strobe, one cycle per issued op.
- resp_id  out  ID_W  index of the requester owning resp_result.
- resp_result  out  32  product low 32 bits, passed through from mul_result.
- perf_issue_cnt  out  16  saturating count of issued multiplies.

Behaviour:
- Reset (async assert, sync release):
  - rr_ptr=0; tag pipeline valid bits=0 and IDs=0; perf_issue_cnt=0.
  - resp_valid=0, resp_id=0; grant=0; mul_src1/mul_src2=0.
- Arbitration (combinational, every cycle):
  - Search req starting at index rr_ptr, wrapping modulo NUM_REQ; the first asserted index g is granted.
  - grant = one-hot(g); mul_src1/mul_src2 = req_src1/req_src2 slice g.
  - If no req is asserted: grant=0 and mul_src1/mul_src2=0.
- Pointer update (registered): on an issue, rr_ptr <= (g+1) mod NUM_REQ; otherwise rr_ptr holds.
  - Consequence: one requester holding req continuously while another also requests gets every other slot.
- Requester protocol:
  - Operand slices must be stable while req=1 and grant bit=0.
  - The cycle after a grant, the requester may keep req=1 with new operands (back-to-back issue).
- Tag pipeline:
  - MUL_LATENCY-deep shift register of {valid, id}; stage 0 loads {issue, g} each clk edge.
  - resp_valid/resp_id = last stage.
  - An op issued in cycle T produces resp_valid=1 in cycle T+MUL_LATENCY with resp_result = mul_result.
- No response backpressure: requesters must accept resp_valid the cycle it is shown. Throughput is 1 op/cycle sustained.
- Arithmetic: the cell computes unsigned 32x32 and keeps the low 32 bits, which also equals the low word of a two's-complement signed multiply. The block itself does no arithmetic on results.
- perf_issue_cnt increments by 1 per issue and saturates at 16'hFFFF (no wrap).
- Simultaneous events: a new issue and a retiring response in the same cycle are independent; both occur.
- Reset mid-operation: all in-flight tags are discarded and no resp_valid appears after release. Requesters must re-request.
- rr_ptr is always kept < NUM_REQ. Non-power-of-two NUM_REQ wraps correctly, e.g. 2 -> 0 for NUM_REQ=3.
- X on req_src of a non-granted requester must not propagate to mul_src.

Decomposition:
- Shared package soc_system_cpu_s1_mul_pkg:
  - MUL_DATA_W=32; PERF_CNT_W=16.
  - Function clog2.
  - Typedef mul_tag_t {logic valid; logic [ID_W-1:0] id}.
- One sub-module, soc_system_cpu_s1_rr_arbiter:
  - Parameterised NUM_REQ.
  - Inputs req, rr_ptr; outputs one-hot grant and encoded index.
  - Purely combinational; reused by other shared-resource blocks.
- Pointer register, tag pipeline, operand mux and perf counter stay in the top module.

Test Plan:
- Single op: NUM_REQ=2, MUL_LATENCY=1; req[0]=1 with src1=0x0001_0003, src2=0x0000_0005 -> grant=2'b01 same cycle; next cycle resp_valid=1, resp_id=0, resp_result=0x0005_000F.
- Contention: req=2'b11 held 4 cycles with distinct operands, rr_ptr=0 -> grants 01,10,01,10; resp_id sequence 0,1,0,1 one cycle later; each result matches its own operands.
- Wrap and latency: NUM_REQ=3, MUL_LATENCY=3; req=3'b101 after a grant to index 1 -> grant index 2 then 0; each resp_valid appears exactly 3 cycles after its grant; src1=0xFFFF_FFFF, src2=2 -> 0xFFFF_FFFE.
- Back-to-back single requester: req[1]=1 for 5 cycles with src1=n, src2=n for n=1..5 -> 5 consecutive resp_valid with results 1,4,9,16,25; perf_issue_cnt=5.
- Reset mid-flight: MUL_LATENCY=2; issue at T; assert reset_n=0 at T+1 -> resp_valid stays 0 through and after release; perf_issue_cnt=0, rr_ptr=0.
- Saturation: force 65,540 issues -> perf_issue_cnt stops at 0xFFFF; idle cycles give grant=0 and mul_src1=mul_src2=0.
